pe_input: RTL

- Router-side receiver for the processing-element injection port; the counterpart of the PE output path.
- Accepts flits from the PE over the pesi/peri/pedi handshake.
- Parks each flit in a one-entry even or odd virtual-channel buffer, selected by the flit's VC bit.
- Raises a request toward the cw or ccw output arbiter, selected by the flit's direction bit, and frees the buffer on grant.

---
 rtl/pe_input_pkg.sv | 29 ++
 rtl/pe_input_vc.sv | 67 ++++++
 rtl/pe_input.sv | 82 ++++++++
 3 files changed

// File: rtl/pe_input_pkg.sv
// Shared definitions for the router input/output blocks: flit field positions,
// VC and direction encodings, and the one-entry buffer state.
package pe_input_pkg;

  localparam int FLIT_W  = 64;
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // A VC may drain only in the phase whose polarity equals its own encoding.
  function automatic logic phase_ok(input vc_e vc, input logic polarity);
    return polarity == logic'(vc);
  endfunction

endpackage

// File: rtl/pe_input_vc.sv
// One-entry virtual-channel buffer: captures a flit, requests the cw or ccw
// arbiter while its phase is active, and empties on the matching grant.
module pe_input_vc
  import pe_input_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_dir,
  input  logic                  phase_ok,
  input  logic                  grant_cw,
  input  logic                  grant_ccw,
  output logic                  request_cw,
  output logic                  request_ccw,
  output logic [DATA_WIDTH-1:0] data_out,
  output buf_state_e            state_next
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  dir_e                  dir_q, dir_d;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    request_cw  = 1'b0;
    request_ccw = 1'b0;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = din;
          dir_d   = dir_e'(din_dir);
        end
      end
      FULL: begin
        request_cw  = (dir_q == DIR_CW)  && phase_ok;
        request_ccw = (dir_q == DIR_CCW) && phase_ok;
        // Only a grant answering the live request frees the entry.
        if ((request_cw && grant_cw) || (request_ccw && grant_ccw)) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dir_q   <= DIR_CW;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  assign data_out   = data_q;
  assign state_next = state_d;

endmodule

// File: rtl/pe_input.sv
// Router-side receiver for the PE injection port: steers each accepted flit to
// the even or odd VC buffer and allows a single outstanding injection.
module pe_input
  import pe_input_pkg::*;
#(
  parameter int DATA_WIDTH = pe_input_pkg::FLIT_W,
  parameter int VC_BIT     = pe_input_pkg::VC_BIT,
  parameter int DIR_BIT    = pe_input_pkg::DIR_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pesi,
  output logic                  peri,
  input  logic [DATA_WIDTH-1:0] pedi,
  input  logic                  polarity,
  output logic                  request_cw_even,
  output logic                  request_ccw_even,
  output logic                  request_cw_odd,
  output logic                  request_ccw_odd,
  input  logic                  grant_cw_even,
  input  logic                  grant_ccw_even,
  input  logic                  grant_cw_odd,
  input  logic                  grant_ccw_odd,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd
);

  logic       peri_q, peri_d;
  logic       accept;
  logic       load_even, load_odd;
  buf_state_e next_even, next_odd;

  assign accept    = pesi && peri_q;
  assign load_even = accept && (pedi[VC_BIT] == logic'(VC_EVEN));
  assign load_odd  = accept && (pedi[VC_BIT] == logic'(VC_ODD));

  pe_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_even (
    .clk         (clk),
    .rst         (rst),
    .load        (load_even),
    .din         (pedi),
    .din_dir     (pedi[DIR_BIT]),
    .phase_ok    (phase_ok(VC_EVEN, polarity)),
    .grant_cw    (grant_cw_even),
    .grant_ccw   (grant_ccw_even),
    .request_cw  (request_cw_even),
    .request_ccw (request_ccw_even),
    .data_out    (data_out_even),
    .state_next  (next_even)
  );

  pe_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_odd (
    .clk         (clk),
    .rst         (rst),
    .load        (load_odd),
    .din         (pedi),
    .din_dir     (pedi[DIR_BIT]),
    .phase_ok    (phase_ok(VC_ODD, polarity)),
    .grant_cw    (grant_cw_odd),
    .grant_ccw   (grant_ccw_odd),
    .request_cw  (request_cw_odd),
    .request_ccw (request_ccw_odd),
    .data_out    (data_out_odd),
    .state_next  (next_odd)
  );

  // Ready only while both buffers will be empty: one flit in flight at a time.
  always_comb begin
    peri_d = (next_even == EMPTY) && (next_odd == EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      peri_q <= 1'b0;
    end else begin
      peri_q <= peri_d;
    end
  end

  assign peri = peri_q;

endmodule
